// File: rtl/uart_rx_word.sv
// uart_rx_word: oversampled UART receiver packing W_OUT/BITS_PER_WORD bytes (LSB byte first) into a valid/ready word stream; define UART_RX_PARITY_EN for an even-parity bit per frame
module uart_rx_word #(
  parameter int CLOCKS_PER_PULSE = 4,
  parameter int BITS_PER_WORD = 8,
  parameter int W_OUT = 24
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             rx,
  output logic             m_valid,
  output logic [W_OUT-1:0] m_data,
  input  logic             m_ready,
  output logic             frame_err,
  output logic             overrun
);
  localparam int NB = W_OUT / BITS_PER_WORD;
  localparam int CW = $clog2(CLOCKS_PER_PULSE);
  localparam int BW = $clog2(BITS_PER_WORD + 1);
  localparam int BCW = NB > 1 ? $clog2(NB) : 1;
  localparam logic [CW-1:0] HALF = CW'(CLOCKS_PER_PULSE / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLOCKS_PER_PULSE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(BITS_PER_WORD - 1);
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(NB - 1);
`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, RECOVER} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, RECOVER} state_t;
`endif
  state_t state, state_nxt;
  logic sync1, rx_s;
  logic [CW-1:0] clk_cnt, clk_cnt_nxt;
  logic [BW-1:0] bit_cnt, bit_cnt_nxt;
  logic [BCW-1:0] byte_cnt, byte_cnt_nxt;
  logic [BITS_PER_WORD-1:0] shreg, shreg_nxt;
  logic [W_OUT-1:0] word, word_nxt, m_data_nxt;
  logic m_valid_nxt, frame_err_nxt, overrun_nxt, done;
  logic par_err, par_err_nxt;
`ifndef UART_RX_PARITY_EN
  assign par_err = 1'b0;
`endif

  // next-state, byte assembly and output handshake
  always_comb begin
    state_nxt = state;
    clk_cnt_nxt = clk_cnt + 1'b1;
    bit_cnt_nxt = bit_cnt;
    byte_cnt_nxt = byte_cnt;
    shreg_nxt = shreg;
    word_nxt = word;
    par_err_nxt = par_err;
    frame_err_nxt = 1'b0;
    overrun_nxt = 1'b0;
    done = 1'b0;
    case (state)
      IDLE: begin
        clk_cnt_nxt = '0;
        if (!rx_s) state_nxt = START;
      end
      START: if (clk_cnt == HALF) begin
        clk_cnt_nxt = '0;
        bit_cnt_nxt = '0;
        state_nxt = rx_s ? IDLE : DATA;
      end
      DATA: if (clk_cnt == FULL) begin
        clk_cnt_nxt = '0;
        shreg_nxt = {rx_s, shreg[BITS_PER_WORD-1:1]};
        bit_cnt_nxt = bit_cnt + 1'b1;
`ifdef UART_RX_PARITY_EN
        if (bit_cnt == LAST_BIT) state_nxt = PARITY;
`else
        if (bit_cnt == LAST_BIT) state_nxt = STOP;
`endif
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (clk_cnt == FULL) begin
        clk_cnt_nxt = '0;
        par_err_nxt = rx_s != ^shreg;
        state_nxt = STOP;
      end
`endif
      STOP: if (clk_cnt == FULL) begin
        clk_cnt_nxt = '0;
        if (!rx_s || par_err) begin
          frame_err_nxt = 1'b1;
          byte_cnt_nxt = '0;
          state_nxt = rx_s ? IDLE : RECOVER;
        end else begin
          word_nxt[byte_cnt*BITS_PER_WORD +: BITS_PER_WORD] = shreg;
          done = byte_cnt == LAST_BYTE;
          byte_cnt_nxt = done ? '0 : byte_cnt + 1'b1;
          state_nxt = IDLE;
        end
      end
      RECOVER: begin
        clk_cnt_nxt = '0;
        if (rx_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    m_valid_nxt = m_valid && !m_ready;
    m_data_nxt = m_data;
    if (done && (!m_valid || m_ready)) begin
      m_valid_nxt = 1'b1;
      m_data_nxt = word_nxt;
    end
    overrun_nxt = done && m_valid && !m_ready;
  end

  // synchronizer and all registered state
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync1 <= 1'b1;
      rx_s <= 1'b1;
      state <= IDLE;
      clk_cnt <= '0;
      bit_cnt <= '0;
      byte_cnt <= '0;
      shreg <= '0;
      word <= '0;
      m_valid <= 1'b0;
      m_data <= '0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err <= 1'b0;
`endif
    end else begin
      sync1 <= rx;
      rx_s <= sync1;
      state <= state_nxt;
      clk_cnt <= clk_cnt_nxt;
      bit_cnt <= bit_cnt_nxt;
      byte_cnt <= byte_cnt_nxt;
      shreg <= shreg_nxt;
      word <= word_nxt;
      m_valid <= m_valid_nxt;
      m_data <= m_data_nxt;
      frame_err <= frame_err_nxt;
      overrun <= overrun_nxt;
`ifdef UART_RX_PARITY_EN
      par_err <= par_err_nxt;
`endif
    end
  end
endmodule

// File: tb/tb_uart_rx_word.sv
// tb_uart_rx_word: directed serial frames into uart_rx_word with hand-computed expected words and flags
module tb_uart_rx_word;
  localparam int CPP = 4;
  logic clk = 0, rstn = 0, rx = 1, m_ready = 1;
  logic m_valid, frame_err, overrun;
  logic [23:0] m_data;
  int checks = 0, errors = 0, cyc = 0, fe_cnt = 0, ov_cnt = 0, rise_cyc = -1, c0, n0, f0, o0;
  logic prev_valid = 0;
  logic [23:0] got[$];

  uart_rx_word dut (.clk(clk), .rstn(rstn), .rx(rx), .m_valid(m_valid), .m_data(m_data),
                    .m_ready(m_ready), .frame_err(frame_err), .overrun(overrun));

  always #5 clk = ~clk;

  // cycle counter
  always @(posedge clk) cyc <= cyc + 1;

  // observe pulses, first m_valid rise and accepted words
  always @(negedge clk) begin
    if (frame_err) fe_cnt <= fe_cnt + 1;
    if (overrun) ov_cnt <= ov_cnt + 1;
    if (m_valid && !prev_valid && rise_cyc < 0) rise_cyc <= cyc;
    prev_valid <= m_valid;
    if (m_valid && m_ready) got.push_back(m_data);
  end

  task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
    checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got_v, exp_v);
    end
  endtask

  task automatic send_bit(input logic v);
    rx = v;
    repeat (CPP) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop = 1, input logic pflip = 0, input int nbits = 11);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(b[i]);
`ifdef UART_RX_PARITY_EN
    bits.push_back(^b ^ pflip);
`endif
    bits.push_back(stop);
    for (int i = 0; i < bits.size() && i < nbits; i++) send_bit(bits[i]);
  endtask

  task automatic send_word(input logic [23:0] w);
    for (int i = 0; i < 3; i++) send_byte(w[8*i +: 8]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rstn = 1;
    check("rst_valid", m_valid, 0);
    check("rst_data", m_data, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovr", overrun, 0);
    idle(5);
    c0 = cyc;
    send_word(24'h123456);
    idle(5);
    check("t1_count", got.size(), 1);
    check("t1_data", got[0], 24'h123456);
`ifndef UART_RX_PARITY_EN
    check("t1_latency", rise_cyc - c0, 121);
`else
    check("t1_latency", rise_cyc - c0, 133);
`endif
    check("t1_ferr", fe_cnt, 0);
    check("t1_ovr", ov_cnt, 0);
    check("t1_valid_drop", m_valid, 0);
    rx = 0;
    @(posedge clk);
    #1;
    idle(20);
    check("t2_count", got.size(), 1);
    check("t2_ferr", fe_cnt, 0);
    check("t2_valid", m_valid, 0);
    send_byte(8'hA5, 0);
    rx = 0;
    repeat (40) @(posedge clk);
    #1;
    idle(10);
    check("t3_ferr_once", fe_cnt, 1);
    send_word(24'hABCDEF);
    idle(5);
    check("t3_count", got.size(), 2);
    check("t3_data", got[$], 24'hABCDEF);
    check("t3_ovr", ov_cnt, 0);
    m_ready = 0;
    send_word(24'h111111);
    idle(5);
    check("t4_valid_held", m_valid, 1);
    send_word(24'h222222);
    idle(5);
    check("t4_ovr_once", ov_cnt, 1);
    check("t4_data_kept", m_data, 24'h111111);
    check("t4_valid_still", m_valid, 1);
    m_ready = 1;
    @(posedge clk);
    #1;
    check("t4_valid_drop", m_valid, 0);
    idle(5);
    check("t4_count", got.size(), 3);
    check("t4_data", got[$], 24'h111111);
    send_byte(8'hBE);
    send_byte(8'hAD, 1, 0, 5);
    rstn = 0;
    rx = 1;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1;
    check("t5_valid", m_valid, 0);
    check("t5_data", m_data, 0);
    idle(10);
    send_word(24'h0000FF);
    idle(5);
    check("t5_count", got.size(), 4);
    check("t5_word", got[$], 24'h0000FF);
`ifdef UART_RX_PARITY_EN
    f0 = fe_cnt;
    send_byte(8'h03, 1, 1);
    idle(5);
    check("t6_ferr", fe_cnt - f0, 1);
    send_word(24'h332211);
    idle(5);
    check("t6_count", got.size(), 5);
    check("t6_word", got[$], 24'h332211);
`endif
    check("end_ferr_total", fe_cnt, 1
`ifdef UART_RX_PARITY_EN
      + 1
`endif
    );
    check("end_ovr_total", ov_cnt, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
